// File: rtl/seg7_pkg.sv
// Shared types, segment patterns and helpers for the 7-segment scan driver.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Index n holds the A..G pattern (A = bit 0) for hex digit n.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic seg_t hex2seg(input logic [3:0] nib);
    return SEG_PATTERNS[nib];
  endfunction

  // Clocks per PWM sub-tick; never below one.
  function automatic int unsigned calc_sub_div(input int unsigned clk_hz,
                                               input int unsigned refresh_hz,
                                               input int unsigned digits,
                                               input int unsigned bright_w);
    int unsigned q;
    q = clk_hz / (refresh_hz * digits * (32'd1 << bright_w));
    return (q == 0) ? 1 : q;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Prescaler, PWM sub-tick counter and digit index for the scan driver.
module seg7_scan_timer #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SUB_DIV  = 1,
  parameter int unsigned BRIGHT_W = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                slot_start_o,
  output logic [BRIGHT_W-1:0] pwm_cnt_o,
  output logic [IDX_W-1:0]    digit_idx_o,
  output logic [IDX_W-1:0]    digit_idx_next_o
);

  localparam int unsigned PRE_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic [IDX_W-1:0]    digit_q, digit_d;
  logic                sub_tick;
  logic                wrap;

  // Next-state for prescaler, PWM counter and digit index.
  always_comb begin
    presc_d  = presc_q;
    pwm_d    = pwm_q;
    digit_d  = digit_q;
    sub_tick = (presc_q == PRE_W'(SUB_DIV - 1));
    wrap     = sub_tick && (pwm_q == '1);
    if (sub_tick) begin
      presc_d = '0;
      pwm_d   = pwm_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    if (wrap) begin
      digit_d = (digit_q == IDX_W'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pwm_q   <= '0;
      digit_q <= '0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      digit_q <= digit_d;
    end
  end

  // slot_start marks the edge on which pwm_cnt enters 0 and digit_idx advances.
  assign slot_start_o     = wrap;
  assign pwm_cnt_o        = pwm_q;
  assign digit_idx_o      = digit_q;
  assign digit_idx_next_o = digit_d;

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadow registers, leading-zero
// blanking, hex decode, PWM enable compare and output polarity.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned REFRESH_HZ    = 1000,
  parameter int unsigned BRIGHT_W      = 4,
  parameter bit          INVERT_DIGITS = 1'b0,
  parameter bit          INVERT_SEGS   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic                  lzb_en_i,
  input  logic                  load_i,
  input  logic [BRIGHT_W-1:0]   brightness_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     digit_en_o
);

  localparam int unsigned SUB_DIV = calc_sub_div(CLK_HZ, REFRESH_HZ, DIGITS, BRIGHT_W);
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                slot_start;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic [IDX_W-1:0]    digit_idx_next;

  seg7_scan_timer #(
    .DIGITS   (DIGITS),
    .SUB_DIV  (SUB_DIV),
    .BRIGHT_W (BRIGHT_W),
    .IDX_W    (IDX_W)
  ) u_scan_timer (
    .clk              (clk),
    .rst_n            (rst_n),
    .slot_start_o     (slot_start),
    .pwm_cnt_o        (pwm_cnt),
    .digit_idx_o      (digit_idx),
    .digit_idx_next_o (digit_idx_next)
  );

  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                lzb_q, lzb_d;
  logic [DIGITS-1:0]   lz_mask_q, lz_mask_d;
  logic                loaded_q, loaded_d;
  logic [DIGITS-1:0]   lz_calc;
  logic                zero_run;

  seg_t                pat_seg_q, pat_seg_d;
  logic                pat_dp_q, pat_dp_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic [3:0]          nib;
  logic                lit;
  logic [DIGITS-1:0]   en_raw;

  logic [6:0]          seg_q, seg_d;
  logic                dp_q_out, dp_d_out;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;

  // Leading-zero mask from the incoming nibbles; digit 0 is never blanked.
  always_comb begin
    lz_calc  = '0;
    zero_run = 1'b1;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (data_i[4*k +: 4] == 4'h0);
      lz_calc[k] = lzb_en_i & zero_run;
    end
  end

  // Shadow capture on load; loaded_q keeps segments dark until the first load.
  always_comb begin
    data_d    = data_q;
    dp_d      = dp_q;
    blank_d   = blank_q;
    lzb_d     = lzb_q;
    lz_mask_d = lz_mask_q;
    loaded_d  = loaded_q;
    if (load_i) begin
      data_d    = data_i;
      dp_d      = dp_i;
      blank_d   = blank_i;
      lzb_d     = lzb_en_i;
      lz_mask_d = lz_calc;
      loaded_d  = 1'b1;
    end
  end

  // Shadow and mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      dp_q      <= '0;
      blank_q   <= '0;
      lzb_q     <= 1'b0;
      lz_mask_q <= '0;
      loaded_q  <= 1'b0;
    end else begin
      data_q    <= data_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
      lzb_q     <= lzb_d;
      lz_mask_q <= lz_mask_d;
      loaded_q  <= loaded_d;
    end
  end

  // Pattern and brightness for the incoming digit, latched only at slot start
  // from the pre-edge shadow so a coincident load lands one slot later.
  always_comb begin
    pat_seg_d = pat_seg_q;
    pat_dp_d  = pat_dp_q;
    bright_d  = bright_q;
    nib       = data_q[4*digit_idx_next +: 4];
    if (slot_start) begin
      bright_d = brightness_i;
      if (!loaded_q || blank_q[digit_idx_next]) begin
        pat_seg_d = SEG_BLANK;
        pat_dp_d  = 1'b0;
      end else if (lz_mask_q[digit_idx_next] && lzb_q) begin
        pat_seg_d = SEG_BLANK;
        pat_dp_d  = dp_q[digit_idx_next];
      end else begin
        pat_seg_d = hex2seg(nib);
        pat_dp_d  = dp_q[digit_idx_next];
      end
    end
  end

  // Per-slot pattern and brightness registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_seg_q <= SEG_BLANK;
      pat_dp_q  <= 1'b0;
      bright_q  <= '0;
    end else begin
      pat_seg_q <= pat_seg_d;
      pat_dp_q  <= pat_dp_d;
      bright_q  <= bright_d;
    end
  end

  // Enable compare: sub-tick 0 is dead time, lit while 1 <= pwm_cnt <= bright_q.
  always_comb begin
    lit    = (pwm_cnt != '0) && (pwm_cnt <= bright_q);
    en_raw = '0;
    if (lit) begin
      en_raw[digit_idx] = 1'b1;
    end
    seg_d      = pat_seg_q ^ {7{INVERT_SEGS}};
    dp_d_out   = pat_dp_q ^ INVERT_SEGS;
    digit_en_d = en_raw ^ {DIGITS{INVERT_DIGITS}};
  end

  // Output registers, reset to the inactive pin levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= {7{INVERT_SEGS}};
      dp_q_out   <= INVERT_SEGS;
      digit_en_q <= {DIGITS{INVERT_DIGITS}};
    end else begin
      seg_q      <= seg_d;
      dp_q_out   <= dp_d_out;
      digit_en_q <= digit_en_d;
    end
  end

  assign seg_o      = seg_q;
  assign dp_o       = dp_q_out;
  assign digit_en_o = digit_en_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver: a normal-polarity and an inverted
// instance share stimulus; the monitor checks each completed 16-clock slot.
module tb_seg7_mux_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blank_i = '0;
  logic        lzb_en_i = 1'b0;
  logic        load_i = 1'b0;
  logic [1:0]  brightness_i = '0;

  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [3:0]  en0, en1;

  seg7_mux_driver #(
    .DIGITS(4), .CLK_HZ(64), .REFRESH_HZ(1), .BRIGHT_W(2),
    .INVERT_DIGITS(1'b0), .INVERT_SEGS(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .dp_i(dp_i), .blank_i(blank_i),
    .lzb_en_i(lzb_en_i), .load_i(load_i), .brightness_i(brightness_i),
    .seg_o(seg0), .dp_o(dp0), .digit_en_o(en0)
  );

  seg7_mux_driver #(
    .DIGITS(4), .CLK_HZ(64), .REFRESH_HZ(1), .BRIGHT_W(2),
    .INVERT_DIGITS(1'b1), .INVERT_SEGS(1'b1)
  ) u_dut_inv (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .dp_i(dp_i), .blank_i(blank_i),
    .lzb_en_i(lzb_en_i), .load_i(load_i), .brightness_i(brightness_i),
    .seg_o(seg1), .dp_o(dp1), .digit_en_o(en1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         m;
    int         digit;
    logic [6:0] seg;
    logic       dp;
    int         on;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  // Clocks since reset release; output slot m spans cyc 16m+1 .. 16m+16.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int         on_cnt [2][4];
  logic [6:0] seg_cap [2];
  logic       dp_cap [2];
  bit         multi [2];
  bit         unstable [2];
  int         pos, slot_m, others;
  logic [6:0] s_obs;
  logic       d_obs;
  logic [3:0] e_obs;
  exp_t       x;

  // Monitor: accumulate one output slot, then pop and compare its expectation.
  always @(negedge clk) begin
    if (rst_n && cyc > 0) begin
      pos    = (cyc - 1) % 16;
      slot_m = (cyc - 1) / 16;
      for (int u = 0; u < 2; u++) begin
        s_obs = (u == 1) ? ~seg1 : seg0;
        d_obs = (u == 1) ? ~dp1  : dp0;
        e_obs = (u == 1) ? ~en1  : en0;
        if (pos == 0) begin
          for (int k = 0; k < 4; k++) on_cnt[u][k] = 0;
          seg_cap[u]  = s_obs;
          dp_cap[u]   = d_obs;
          multi[u]    = 1'b0;
          unstable[u] = 1'b0;
        end
        if ($countones(e_obs) > 1) multi[u] = 1'b1;
        if (s_obs != seg_cap[u] || d_obs != dp_cap[u]) unstable[u] = 1'b1;
        for (int k = 0; k < 4; k++) if (e_obs[k]) on_cnt[u][k]++;
      end
      if (pos == 15 && q.size() > 0) begin
        if (q[0].m < slot_m) begin
          checks++; errors++;
          $display("FAIL sb_order: expectation for slot %0d not matched, now at slot %0d", q[0].m, slot_m);
          void'(q.pop_front());
        end else if (q[0].m == slot_m) begin
          x = q.pop_front();
          for (int u = 0; u < 2; u++) begin
            checks++;
            if (seg_cap[u] !== x.seg) begin
              errors++;
              $display("FAIL seg dut%0d slot %0d: got %h expected %h", u, slot_m, seg_cap[u], x.seg);
            end
            checks++;
            if (dp_cap[u] !== x.dp) begin
              errors++;
              $display("FAIL dp dut%0d slot %0d: got %b expected %b", u, slot_m, dp_cap[u], x.dp);
            end
            checks++;
            if (on_cnt[u][x.digit] != x.on) begin
              errors++;
              $display("FAIL en_count dut%0d slot %0d digit %0d: got %0d expected %0d",
                       u, slot_m, x.digit, on_cnt[u][x.digit], x.on);
            end
            others = 0;
            for (int k = 0; k < 4; k++) if (k != x.digit) others += on_cnt[u][k];
            checks++;
            if (others != 0 || multi[u] || unstable[u]) begin
              errors++;
              $display("FAIL en_other dut%0d slot %0d: other-digit clocks %0d multi %0b seg_changed %0b expected 0 0 0",
                       u, slot_m, others, multi[u], unstable[u]);
            end
          end
        end
      end
    end
  end

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc != c) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        checks++; errors++;
        $display("FAIL wait_cyc: got cyc %0d expected %0d within 5000 clocks", cyc, c);
        finish_sim();
      end
    end
  endtask

  task automatic load_at(input int e, input logic [15:0] d, input logic [3:0] dpv,
                         input logic [3:0] bl, input logic lz);
    wait_cyc(e - 1);
    data_i   = d;
    dp_i     = dpv;
    blank_i  = bl;
    lzb_en_i = lz;
    load_i   = 1'b1;
    @(negedge clk);
    load_i   = 1'b0;
  endtask

  task automatic set_bright_at(input int c, input logic [1:0] b);
    wait_cyc(c);
    brightness_i = b;
  endtask

  task automatic exp1(input int m, input int d, input logic [6:0] s, input logic p, input int on);
    exp_t r;
    r.m = m; r.digit = d; r.seg = s; r.dp = p; r.on = on;
    q.push_back(r);
  endtask

  task automatic exp4(input int m0, input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3,
                      input logic [3:0] dpv, input int on);
    exp1(m0,     0, s0, dpv[0], on);
    exp1(m0 + 1, 1, s1, dpv[1], on);
    exp1(m0 + 2, 2, s2, dpv[2], on);
    exp1(m0 + 3, 3, s3, dpv[3], on);
  endtask

  task automatic check_inactive(input string name);
    checks++;
    if (seg0 !== 7'h00 || dp0 !== 1'b0 || en0 !== 4'h0) begin
      errors++;
      $display("FAIL %s dut0: got seg %h dp %b en %h expected 00 0 0", name, seg0, dp0, en0);
    end
    checks++;
    if (seg1 !== 7'h7F || dp1 !== 1'b1 || en1 !== 4'hF) begin
      errors++;
      $display("FAIL %s dut1: got seg %h dp %b en %h expected 7f 1 f", name, seg1, dp1, en1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_inactive("reset");
    exp4(0, 7'h00, 7'h00, 7'h00, 7'h00, 4'b0000, 0);
    rst_n = 1'b1;

    // Frame 1: 1234 at full brightness, loaded mid digit-3 slot.
    set_bright_at(50, 2'd3);
    load_at(56, 16'h1234, 4'b0000, 4'b0000, 1'b0);
    exp4(4, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, 12);

    // Frames 2..5: brightness 0..3 gives 0, 4, 8, 12 lit clocks per slot.
    for (int k = 2; k <= 5; k++) begin
      set_bright_at(64 * k - 8, 2'(k - 2));
      exp4(4 * k, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, 4 * (k - 2));
    end

    // Leading-zero blanking, dp survives on a blanked leading digit.
    load_at(376, 16'h0070, 4'b1000, 4'b0000, 1'b1);
    exp4(24, 7'h3F, 7'h07, 7'h00, 7'h00, 4'b1000, 12);
    load_at(440, 16'h0000, 4'b0000, 4'b0000, 1'b1);
    exp4(28, 7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, 12);

    // Forced blank on digit 1 kills its dp too.
    load_at(504, 16'hFFFF, 4'b1111, 4'b0010, 1'b0);
    exp4(32, 7'h71, 7'h00, 7'h71, 7'h71, 4'b1101, 12);
    exp4(36, 7'h71, 7'h00, 7'h71, 7'h06, 4'b0101, 12);

    // Mid-slot load inside digit 2's slot: digit 2 keeps F, digit 3 picks up 1.
    load_at(616, 16'h1234, 4'b0000, 4'b0000, 1'b0);
    exp4(40, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, 12);

    // Load on the same edge as a slot start: that slot still shows the old 4.
    load_at(704, 16'hABCD, 4'b0000, 4'b0000, 1'b0);
    exp4(44, 7'h66, 7'h39, 7'h7C, 7'h77, 4'b0000, 12);
    exp1(48, 0, 7'h5E, 1'b0, 12);

    // Asynchronous reset in the middle of a lit sub-tick.
    wait_cyc(808);
    #2 rst_n = 1'b0;
    #1 check_inactive("async_reset");
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expectations expected 0", q.size());
    end
    q.delete();
    repeat (2) @(negedge clk);
    check_inactive("reset_hold");
    rst_n = 1'b1;

    // Scan restarts at digit 0 with cleared shadow and bright_q.
    exp1(0, 0, 7'h00, 1'b0, 0);
    load_at(8, 16'hABCD, 4'b0000, 4'b0000, 1'b0);
    exp1(1, 1, 7'h39, 1'b0, 12);
    exp1(2, 2, 7'h7C, 1'b0, 12);
    exp1(3, 3, 7'h77, 1'b0, 12);
    exp1(4, 0, 7'h5E, 1'b0, 12);
    wait_cyc(82);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_final: got %0d pending expectations expected 0", q.size());
    end
    finish_sim();
  end

endmodule
